// File: rtl/mealy_fsm_pkg.sv
// Shared constants and state type for the BCD sequence detector.
package mealy_fsm_pkg;

  localparam int N       = 4;
  localparam int SEQ_LEN = 8;

  localparam logic [N-1:0] SEQ [0:SEQ_LEN-1] = '{
    4'd8, 4'd2, 4'd4, 4'd4, 4'd4, 4'd3, 4'd0, 4'd0
  };

  // Sk encodes k directly so the match index is the low three bits.
  typedef enum logic [3:0] {
    S0   = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    S7   = 4'd7,
    IDLE = 4'd8
  } state_e;

endpackage

// File: rtl/mealy_fsm.sv
// Mealy detector for the digit sequence SEQ, armed by start, one digit per clock.
module mealy_fsm
  import mealy_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         asyn_n_rst,
  input  logic         start,
  input  logic [N-1:0] digit_in,
  output logic         sequence_detected
);

  state_e     state_q, state_d;
  logic [2:0] k;

  always_ff @(posedge clk or posedge asyn_n_rst) begin
    if (asyn_n_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    sequence_detected = 1'b0;
    k                 = state_q[2:0];
    if (start) begin
      state_d = S0;
    end else if (state_q != IDLE) begin
      if (state_q == S7 && digit_in == SEQ[SEQ_LEN-1]) begin
        sequence_detected = 1'b1;
        state_d           = S0;
      end else if (state_q != S7 && digit_in == SEQ[k]) begin
        state_d = state_e'(state_q + 4'd1);
      end else if (digit_in == SEQ[0]) begin
        // the only self-overlap of SEQ is its leading digit
        state_d = S1;
      end else begin
        state_d = S0;
      end
    end
  end

endmodule

// File: tb/tb_mealy_fsm.sv
// Directed plus randomized checks of mealy_fsm against a sliding-window model.
module tb_mealy_fsm;

  logic       clk = 1'b0;
  logic       asyn_n_rst;
  logic       start;
  logic [3:0] digit_in;
  logic       sequence_detected;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses;
  int pulse_cyc [$];

  logic [3:0] ref_seq [0:7];
  logic       armed;
  logic [3:0] hist [$];

  mealy_fsm dut (
    .clk              (clk),
    .asyn_n_rst       (asyn_n_rst),
    .start            (start),
    .digit_in         (digit_in),
    .sequence_detected(sequence_detected)
  );

  always #5 clk = ~clk;

  // Detection means: armed, no start, and the last 7 armed digits plus the
  // current one spell out the target sequence.
  function automatic logic model_det(input logic [3:0] d, input logic s);
    int n;
    if (!armed || s) return 1'b0;
    n = hist.size();
    if (n < 7) return 1'b0;
    for (int i = 0; i < 7; i++)
      if (hist[n-7+i] != ref_seq[i]) return 1'b0;
    return d == ref_seq[7];
  endfunction

  task automatic model_clock(input logic [3:0] d, input logic s);
    if (s) begin
      armed = 1'b1;
      hist.delete();
    end else if (armed) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic model_reset();
    armed = 1'b0;
    hist.delete();
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; output sampled on falling edge.
  task automatic step(input logic [3:0] d, input logic s, input string tag);
    logic e;
    digit_in = d;
    start    = s;
    @(negedge clk);
    e = model_det(d, s);
    check(tag, sequence_detected, e);
    if (sequence_detected === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_clock(d, s);
    cyc++;
    #1;
  endtask

  task automatic feed_seq(input int cnt, input string tag);
    for (int i = 0; i < cnt; i++) step(ref_seq[i], 1'b0, tag);
  endtask

  initial begin
    logic [3:0] d;
    logic       s;
    int         pos;
    ref_seq = '{4'd8, 4'd2, 4'd4, 4'd4, 4'd4, 4'd3, 4'd0, 4'd0};
    model_reset();
    pulses     = 0;
    asyn_n_rst = 1'b1;
    start      = 1'b0;
    digit_in   = 4'd0;
    #12;
    check("reset_out", sequence_detected, 1'b0);
    digit_in = 4'd0;
    @(negedge clk);
    asyn_n_rst = 1'b0;
    @(posedge clk); #1;

    // no start: stays idle
    feed_seq(8, "no_start");

    // basic detection
    step(4'd0, 1'b1, "arm");
    feed_seq(8, "basic");
    step(4'd8, 1'b0, "after_det");
    step(4'd5, 1'b0, "after_det2");

    // mismatch restart on 8
    step(4'd0, 1'b1, "arm2");
    for (int i = 0; i < 3; i++) step(ref_seq[i], 1'b0, "mm_pre");
    step(4'd9, 1'b0, "mm_9");
    feed_seq(8, "mm_full");

    // start has priority over final digit
    step(4'd0, 1'b1, "arm3");
    feed_seq(7, "prio_pre");
    step(4'd0, 1'b1, "prio_start");
    feed_seq(8, "prio_after");

    // two back-to-back sequences
    step(4'd0, 1'b1, "arm4");
    pulses = 0;
    pulse_cyc.delete();
    feed_seq(8, "b2b_1");
    feed_seq(8, "b2b_2");
    check("b2b_count", pulses == 2, 1'b1);
    if (pulse_cyc.size() == 2) check("b2b_gap", (pulse_cyc[1] - pulse_cyc[0]) == 8, 1'b1);

    // async reset in S5 between edges
    step(4'd0, 1'b1, "arm5");
    feed_seq(5, "rst_pre");
    digit_in = ref_seq[5];
    #2;
    asyn_n_rst = 1'b1;
    model_reset();
    #1;
    check("rst_s5_out", sequence_detected, 1'b0);
    @(negedge clk);
    asyn_n_rst = 1'b0;
    @(posedge clk); #1;
    feed_seq(8, "rst_noarm");
    step(4'd0, 1'b1, "arm6");
    feed_seq(8, "rst_after");

    // async reset while output is high in S7
    step(4'd0, 1'b1, "arm7");
    feed_seq(7, "rst7_pre");
    digit_in = 4'd0;
    start    = 1'b0;
    #2;
    check("s7_high", sequence_detected, 1'b1);
    asyn_n_rst = 1'b1;
    model_reset();
    #1;
    check("rst_s7_out", sequence_detected, 1'b0);
    @(negedge clk);
    asyn_n_rst = 1'b0;
    @(posedge clk); #1;

    // randomized, biased toward the target digits
    pos = 0;
    for (int n = 0; n < 600; n++) begin
      s = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) begin
        d = 4'($urandom_range(0, 15));
      end else begin
        d   = ref_seq[pos];
        pos = (pos + 1) % 8;
      end
      if (s) pos = 0;
      step(d, s, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mealy_fsm.md
MEALY_FSM -- requirements
Module: mealy_fsm

Interface
REQ-001 Package parameter N, default 4: digit width in bits, one BCD digit per clock.
REQ-002 Package constant SEQ, default 8,2,4,4,4,3,0,0 (first to last): the target digit sequence, length 8.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 asyn_n_rst  input  1  asynchronous, active-high reset; keeps the codebase name despite the "_n" suffix.
REQ-005 start  input  1  synchronous request to (re)arm detection from the first sequence digit.
REQ-006 digit_in  input  N  digit sampled on every rising edge while armed.
REQ-007 sequence_detected  output  1  Mealy output; high while the final SEQ digit is present on digit_in in the armed last-match state.

Function
REQ-008 The block SHALL implement states IDLE, S0..S7, where Sk means the first k digits of SEQ are matched.
REQ-009 In IDLE, digit_in SHALL be ignored; start=1 SHALL move the FSM to S0, otherwise it stays in IDLE.
REQ-010 In any state, start=1 on a clock edge SHALL move the FSM to S0, regardless of digit_in (start has priority).
REQ-011 In Sk (k=0..6) with start=0, digit_in==SEQ[k] SHALL move the FSM to Sk+1.
REQ-012 In Sk (k=0..7) with start=0 and digit_in!=SEQ[k], the FSM SHALL go to S1 if digit_in==8, else to S0 (longest-prefix overlap; SEQ has no other self-overlap).
REQ-013 In S7 with start=0 and digit_in==0, the FSM SHALL go to S0 (0 is not the SEQ prefix 8).
REQ-014 sequence_detected SHALL be purely combinational: (state==S7) AND (digit_in==SEQ[7]) AND (start==0).
REQ-015 sequence_detected SHALL be 0 in IDLE, in S0..S6, and whenever start=1.
REQ-016 Detection latency SHALL be 0 cycles: the output rises in the same cycle the 8th digit is applied and drops after the next edge, unless S7 is re-entered.
REQ-017 digit_in values 9..15 SHALL be treated as ordinary mismatches, with no error indication.
REQ-018 The FSM SHALL stay armed after a detection; consecutive sequences SHALL be detected without a new start.

Reset
REQ-019 asyn_n_rst=1 SHALL force state to IDLE immediately, independent of clk.
REQ-020 sequence_detected SHALL read 0 while reset is asserted.
REQ-021 Reset asserted mid-sequence SHALL discard all progress; after release, a start is required before detection resumes.
REQ-022 Reset release SHALL take effect at the first rising edge after deassertion; no reset synchronizer is inside this block.

Structure
REQ-023 Package mealy_fsm_pkg SHALL hold N, SEQ, and the state enum type (IDLE, S0..S7).
REQ-024 The design SHALL use one module with a state register and a combinational next-state/output block; no sub-module.
REQ-025 The state register SHALL be the only storage element.

Verification
REQ-026 Reset, then start=1 for one cycle, then digits 8,2,4,4,4,3,0,0 on consecutive edges -> sequence_detected=1 only during the cycle digit_in=0 in S7, then 0.
REQ-027 After arming, digits 8,2,4,9,8,2,4,4,4,3,0,0 -> no detection at the mismatch digit 9; detection on the final 0 (the 8 after the mismatch restarts matching at S1).
REQ-028 Digits 8,2,4,4,4,3,0,0 without start after reset -> sequence_detected stays 0 (FSM remains in IDLE).
REQ-029 Armed, digits 8,2,4,4,4,3,0, then start=1 with digit_in=0 -> sequence_detected=0 and state=S0.
REQ-030 Assert asyn_n_rst between clock edges while in S5 -> state=IDLE immediately and output 0; after release plus start, a full sequence is detected.
REQ-031 Two back-to-back full sequences after one start -> exactly two single-cycle sequence_detected pulses, 8 cycles apart.
